tc_cu_gen: RTL and testbench
============================

Name: tc_cu_gen

Overview:
- Parametrised tiled-GEMM control unit. It sequences the LOAD, COMPUTE and OUTPUT phases for a D = A·B array of size M×K × K×N.
- Issues tile pointers to the MAC array through a valid/ready handshake, selects the loop order at runtime, and streams result rows out under backpressure.
- Sits between the host/DMA sequencer and the tile datapath (operand buffers, MAC array, accumulator RAM).
- Successor to the fixed 16×16×16 / 4×4×4 controller: generic sizes, stalls, abort and done signalling added.

Parameters:
- M, 16: rows of A and D; must be a multiple of TILE_M.
- N, 16: columns of B and D; must be a multiple of TILE_N.
- K, 16: reduction depth; must be a multiple of TILE_K.
- TILE_M, 4: tile height.
- TILE_N, 4: tile width.
- TILE_K, 4: tile depth.
- PTR_W, 8: pointer width; must satisfy 2^PTR_W > max(M,N,K).
- ROW_W, 8: row-index width; must satisfy 2^ROW_W > M.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- start  in  1  begin a job; sampled only in IDLE.
- loop_order  in  1  latched on accepted start. 0 = m inner / k mid / n outer. 1 = k inner / m mid / n outer.
- load_done  in  1  operand buffers filled; LOAD→COMPUTE.
- abort  in  1  return to IDLE next cycle.
- tile_ready  in  1  MAC array accepts a tile this cycle.
- out_ready  in  1  downstream accepts a row this cycle.
- ptr_m  out  PTR_W  current tile row base.
- ptr_n  out  PTR_W  current tile column base.
- ptr_k  out  PTR_W  current tile depth base.
- tile_valid  out  1  pointers valid; high throughout COMPUTE.
- write_d  out  1  tile_valid & tile_ready; accumulator write strobe.
- acc_first  out  1  tile_valid & ptr_k==0; accumulator clears instead of adding.
- acc_last  out  1  tile_valid & ptr_k==K-TILE_K.
- out_valid  out  1  row_out valid.
- row_out  out  ROW_W  result row index, 0..M-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last row is accepted.

Behaviour:
- States: IDLE, LOAD, COMPUTE, OUTPUT; all transitions registered.
- Reset (reset==0 at clk edge): state=IDLE; all pointers=0; row_out=0; loop_order latch=0. All outputs 0, including done.
- IDLE→LOAD on start==1. The loop order is latched and pointers are zeroed on the same edge. start outside IDLE is ignored.
- LOAD→COMPUTE on load_done==1. Pointers hold at 0.
- COMPUTE, handshake: tile_valid=1. Pointers advance only on an edge where tile_ready==1; with tile_ready==0 all outputs hold (stall of any length).
- COMPUTE, order 0: the inner counter m steps by TILE_M. On wrap, m→0 and k steps; when k wraps, k→0 and n steps.
- COMPUTE, order 1: the same scheme with k inner, m middle, n outer.
- Tile count is (M/TILE_M)·(N/TILE_N)·(K/TILE_K). Each (m,n,k) triple is issued exactly once.
- COMPUTE→OUTPUT on handshake of the last tile: m=M-TILE_M, k=K-TILE_K, n=N-TILE_N. Pointers then hold their final values; row_out=0 on entry.
- OUTPUT: out_valid=1. row_out increments on out_valid & out_ready.
- OUTPUT→IDLE on acceptance of row M-1; done pulses 1 on the following cycle (first IDLE cycle).
- abort (any state other than IDLE): next state IDLE, pointers and row_out cleared, no done pulse. abort has priority over every other transition. reset has priority over abort.
- A degenerate config with single-tile dims (e.g. M==TILE_M) is legal; that counter never advances.
- Latency: LOAD→first tile is 1 cycle after load_done. With tile_ready held high, one tile issues per cycle.

Optional Feature:
- Macro TC_CU_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_busy_cyc (cycles with busy=1) and perf_stall_cyc (COMPUTE cycles with tile_ready==0, plus OUTPUT cycles with out_ready==0).
  - Counters clear on accepted start and on reset, saturate at all-ones, and hold after done.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package tc_pkg holds:
  - state encoding constants: IDLE=2'd0, LOAD=2'd1, COMPUTE=2'd2, OUTPUT=2'd3;
  - loop-order constants: ORDER_MKN=1'b0, ORDER_KMN=1'b1;
  - the shared default tile sizes.
- One sub-module, tc_tile_iter: a three-level nested counter.
  - Inputs: step, clear, order. Outputs: pointers and last flag.
  - The FSM plus row/output logic stay in tc_cu_gen.

Test Plan:
- Default params, order 0, tile_ready=1: start, load_done → 64 tiles on consecutive cycles, m fastest. First (0,0,0), 5th (m=0,k=4,n=0), last (12,12,12). Then row_out 0..15 with out_ready=1, and done pulses once.
- Order 1: tile sequence has k fastest. 2nd tile is (m=0,k=4,n=0), 5th is (4,0,0). acc_first is high exactly 16 times and acc_last exactly 16 times.
- tile_ready toggled 1,0,0,1…: pointers hold during low cycles, write_d is high only on handshakes, and the total write_d count is 64.
- abort asserted mid-COMPUTE at tile 20 → IDLE next cycle, busy=0, done stays 0. A new start then restarts from (0,0,0).
- reset=0 during OUTPUT at row 7 → next cycle all outputs 0 and state IDLE. out_ready=0 in OUTPUT holds row_out.
- Params M=8, N=12, K=4, TILE 4 → 6 tiles. K single-tile, so acc_first=acc_last=1 on every tile. 8 rows are output.

Source files
------------

// File: rtl/tc_cu_gen_pkg.sv
// ============================================================================
// Module   : tc_pkg
// Brief    : Shared state encoding, loop-order codes and default tile sizes
//            for the tiled-GEMM control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    localparam logic ORDER_MKN = 1'b0;
    localparam logic ORDER_KMN = 1'b1;

    localparam int DEF_DIM    = 16;
    localparam int DEF_TILE_M = 4;
    localparam int DEF_TILE_N = 4;
    localparam int DEF_TILE_K = 4;
    localparam int DEF_PTR_W  = 8;
    localparam int DEF_ROW_W  = 8;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tc_cu_gen_if.sv
// ============================================================================
// Module   : tc_cu_if
// Brief    : Host/datapath bundle of the GEMM control unit. Optional perf
//            counter signals appear when TC_CU_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tc_cu_if #(
    parameter int PTR_W = 8,
    parameter int ROW_W = 8
);
    logic             start;
    logic             loop_order;
    logic             load_done;
    logic             abort;
    logic             tile_ready;
    logic             out_ready;
    logic [PTR_W-1:0] ptr_m;
    logic [PTR_W-1:0] ptr_n;
    logic [PTR_W-1:0] ptr_k;
    logic             tile_valid;
    logic             write_d;
    logic             acc_first;
    logic             acc_last;
    logic             out_valid;
    logic [ROW_W-1:0] row_out;
    logic             busy;
    logic             done;
`ifdef TC_CU_PERF_CNT_EN
    logic [31:0]      perf_busy_cyc;
    logic [31:0]      perf_stall_cyc;
`endif

    modport master (
        output start, loop_order, load_done, abort, tile_ready, out_ready,
        input  ptr_m, ptr_n, ptr_k, tile_valid, write_d, acc_first, acc_last,
               out_valid, row_out, busy, done
`ifdef TC_CU_PERF_CNT_EN
        , input perf_busy_cyc, perf_stall_cyc
`endif
    );

    modport slave (
        input  start, loop_order, load_done, abort, tile_ready, out_ready,
        output ptr_m, ptr_n, ptr_k, tile_valid, write_d, acc_first, acc_last,
               out_valid, row_out, busy, done
`ifdef TC_CU_PERF_CNT_EN
        , output perf_busy_cyc, perf_stall_cyc
`endif
    );

endinterface

`default_nettype wire

// File: rtl/tc_cu_gen_tile_iter.sv
// ============================================================================
// Module   : tc_tile_iter
// Brief    : Three-level nested tile pointer counter, n always outermost;
//            order selects whether m or k is the innermost loop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_tile_iter
    import tc_pkg::*;
#(
    parameter int M      = DEF_DIM,
    parameter int N      = DEF_DIM,
    parameter int K      = DEF_DIM,
    parameter int TILE_M = DEF_TILE_M,
    parameter int TILE_N = DEF_TILE_N,
    parameter int TILE_K = DEF_TILE_K,
    parameter int PTR_W  = DEF_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             clear,
    input  logic             order,
    output logic [PTR_W-1:0] ptr_m,
    output logic [PTR_W-1:0] ptr_n,
    output logic [PTR_W-1:0] ptr_k,
    output logic             last
);

    localparam logic [PTR_W-1:0] c_M_LAST = PTR_W'(M - TILE_M);
    localparam logic [PTR_W-1:0] c_N_LAST = PTR_W'(N - TILE_N);
    localparam logic [PTR_W-1:0] c_K_LAST = PTR_W'(K - TILE_K);
    localparam logic [PTR_W-1:0] c_TM     = PTR_W'(TILE_M);
    localparam logic [PTR_W-1:0] c_TN     = PTR_W'(TILE_N);
    localparam logic [PTR_W-1:0] c_TK     = PTR_W'(TILE_K);

    logic [PTR_W-1:0] r_m;
    logic [PTR_W-1:0] r_n;
    logic [PTR_W-1:0] r_k;
    logic             w_m_wrap;
    logic             w_n_wrap;
    logic             w_k_wrap;

    assign w_m_wrap = (r_m == c_M_LAST);
    assign w_n_wrap = (r_n == c_N_LAST);
    assign w_k_wrap = (r_k == c_K_LAST);

    // A single-tile dimension has a wrap flag that is always set, so its counter never moves.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (step) begin
            if (order == ORDER_MKN) begin
                r_m <= w_m_wrap ? '0 : r_m + c_TM;
                if (w_m_wrap) begin
                    r_k <= w_k_wrap ? '0 : r_k + c_TK;
                    if (w_k_wrap) r_n <= w_n_wrap ? '0 : r_n + c_TN;
                end
            end else begin
                r_k <= w_k_wrap ? '0 : r_k + c_TK;
                if (w_k_wrap) begin
                    r_m <= w_m_wrap ? '0 : r_m + c_TM;
                    if (w_m_wrap) r_n <= w_n_wrap ? '0 : r_n + c_TN;
                end
            end
        end
    end

    assign ptr_m = r_m;
    assign ptr_n = r_n;
    assign ptr_k = r_k;
    assign last  = w_m_wrap & w_n_wrap & w_k_wrap;

endmodule

`default_nettype wire

// File: rtl/tc_cu_gen.sv
// ============================================================================
// Module   : tc_cu_gen
// Brief    : Tiled-GEMM control unit: LOAD / COMPUTE / OUTPUT sequencing.
//            Optional cycle counters enabled by TC_CU_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_cu_gen
    import tc_pkg::*;
#(
    parameter int M      = DEF_DIM,
    parameter int N      = DEF_DIM,
    parameter int K      = DEF_DIM,
    parameter int TILE_M = DEF_TILE_M,
    parameter int TILE_N = DEF_TILE_N,
    parameter int TILE_K = DEF_TILE_K,
    parameter int PTR_W  = DEF_PTR_W,
    parameter int ROW_W  = DEF_ROW_W
) (
    input  logic    clk,
    input  logic    reset,
    tc_cu_if.slave  bus
);

    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(M - 1);
    localparam logic [PTR_W-1:0] c_K_LAST   = PTR_W'(K - TILE_K);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_order;
    logic [ROW_W-1:0] r_row;
    logic             r_done;
    logic             w_start_acc;
    logic             w_abort;
    logic             w_iter_step;
    logic             w_iter_clear;
    logic             w_iter_last;
    logic             w_row_last;
    logic [PTR_W-1:0] w_ptr_m;
    logic [PTR_W-1:0] w_ptr_n;
    logic [PTR_W-1:0] w_ptr_k;

    assign w_start_acc = (r_state == IDLE) & bus.start;
    assign w_abort     = (r_state != IDLE) & bus.abort;
    assign w_row_last  = (r_row == c_ROW_LAST);

    tc_tile_iter #(
        .M      (M),
        .N      (N),
        .K      (K),
        .TILE_M (TILE_M),
        .TILE_N (TILE_N),
        .TILE_K (TILE_K),
        .PTR_W  (PTR_W)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .step   (w_iter_step),
        .clear  (w_iter_clear),
        .order  (r_order),
        .ptr_m  (w_ptr_m),
        .ptr_n  (w_ptr_n),
        .ptr_k  (w_ptr_k),
        .last   (w_iter_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_order <= ORDER_MKN;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == OUTPUT) & ~bus.abort & bus.out_ready & w_row_last;
            if (w_start_acc) r_order <= bus.loop_order;
            // Row index lives only in OUTPUT; it is zero on entry and after any exit.
            if (r_state == OUTPUT && !bus.abort) begin
                if (bus.out_ready) r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_row <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_iter_step  = 1'b0;
        w_iter_clear = 1'b0;
        if (w_abort) begin
            w_state_nxt  = IDLE;
            w_iter_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_nxt  = LOAD;
                        w_iter_clear = 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.load_done) w_state_nxt = COMPUTE;
                end
                COMPUTE: begin
                    // The final tile does not step, so pointers keep their last values.
                    if (bus.tile_ready) begin
                        if (w_iter_last) w_state_nxt = OUTPUT;
                        else             w_iter_step = 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready && w_row_last) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign bus.ptr_m      = w_ptr_m;
    assign bus.ptr_n      = w_ptr_n;
    assign bus.ptr_k      = w_ptr_k;
    assign bus.tile_valid = (r_state == COMPUTE);
    assign bus.write_d    = (r_state == COMPUTE) & bus.tile_ready;
    assign bus.acc_first  = (r_state == COMPUTE) & (w_ptr_k == '0);
    assign bus.acc_last   = (r_state == COMPUTE) & (w_ptr_k == c_K_LAST);
    assign bus.out_valid  = (r_state == OUTPUT);
    assign bus.row_out    = r_row;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;

`ifdef TC_CU_PERF_CNT_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!reset || w_start_acc) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_state != IDLE) r_perf_busy <= sat_inc32(r_perf_busy);
            if ((r_state == COMPUTE && !bus.tile_ready) ||
                (r_state == OUTPUT  && !bus.out_ready))
                r_perf_stall <= sat_inc32(r_perf_stall);
        end
    end

    assign bus.perf_busy_cyc  = r_perf_busy;
    assign bus.perf_stall_cyc = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tc_cu_gen.sv
// ============================================================================
// Module   : tb_tc_cu_gen
// Brief    : Self-checking bench: default 16x16x16 unit plus an 8x12x4 unit,
//            compared each cycle against a tile-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc_cu_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [1:0]      st, lo, ld, ab, tr, orr;
    logic [1:0][7:0] pm, pn, pk, ro;
    logic [1:0]      tv, wd, af, al, ov, bz, dn;

    tc_cu_if #(.PTR_W(8), .ROW_W(8)) if0 ();
    tc_cu_if #(.PTR_W(8), .ROW_W(8)) if1 ();

    assign if0.start = st[0];      assign if1.start = st[1];
    assign if0.loop_order = lo[0]; assign if1.loop_order = lo[1];
    assign if0.load_done = ld[0];  assign if1.load_done = ld[1];
    assign if0.abort = ab[0];      assign if1.abort = ab[1];
    assign if0.tile_ready = tr[0]; assign if1.tile_ready = tr[1];
    assign if0.out_ready = orr[0]; assign if1.out_ready = orr[1];
    assign pm[0] = if0.ptr_m;  assign pm[1] = if1.ptr_m;
    assign pn[0] = if0.ptr_n;  assign pn[1] = if1.ptr_n;
    assign pk[0] = if0.ptr_k;  assign pk[1] = if1.ptr_k;
    assign ro[0] = if0.row_out; assign ro[1] = if1.row_out;
    assign tv[0] = if0.tile_valid; assign tv[1] = if1.tile_valid;
    assign wd[0] = if0.write_d;    assign wd[1] = if1.write_d;
    assign af[0] = if0.acc_first;  assign af[1] = if1.acc_first;
    assign al[0] = if0.acc_last;   assign al[1] = if1.acc_last;
    assign ov[0] = if0.out_valid;  assign ov[1] = if1.out_valid;
    assign bz[0] = if0.busy;       assign bz[1] = if1.busy;
    assign dn[0] = if0.done;       assign dn[1] = if1.done;

    tc_cu_gen u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    tc_cu_gen #(.M(8), .N(12), .K(4)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    function automatic int dim_m(int d); return (d == 0) ? 16 : 8;  endfunction
    function automatic int dim_n(int d); return (d == 0) ? 16 : 12; endfunction
    function automatic int dim_k(int d); return (d == 0) ? 16 : 4;  endfunction
    function automatic int n_tiles(int d);
        return (dim_m(d) / 4) * (dim_n(d) / 4) * (dim_k(d) / 4);
    endfunction
    // Tile number i -> base coordinates, derived directly from the loop nesting.
    function automatic int t_m(int d, int i, bit o);
        int mt = dim_m(d) / 4; int kt = dim_k(d) / 4;
        return o ? ((i / kt) % mt) * 4 : (i % mt) * 4;
    endfunction
    function automatic int t_k(int d, int i, bit o);
        int mt = dim_m(d) / 4; int kt = dim_k(d) / 4;
        return o ? (i % kt) * 4 : ((i / mt) % kt) * 4;
    endfunction
    function automatic int t_n(int d, int i);
        return (i / ((dim_m(d) / 4) * (dim_k(d) / 4))) * 4;
    endfunction

    // Reference model: phase 0 idle, 1 load, 2 compute, 3 output.
    int ph[2], idx[2], row[2], em[2], en[2], ek[2];
    bit mo[2], edn[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                ph[d] <= 0; idx[d] <= 0; row[d] <= 0; mo[d] <= 1'b0; edn[d] <= 1'b0;
                em[d] <= 0; en[d] <= 0; ek[d] <= 0;
            end else begin
                edn[d] <= 1'b0;
                if (ph[d] != 0 && ab[d]) begin
                    ph[d] <= 0; row[d] <= 0; em[d] <= 0; en[d] <= 0; ek[d] <= 0;
                end else begin
                    case (ph[d])
                        0: if (st[d]) begin
                            ph[d] <= 1; mo[d] <= lo[d]; idx[d] <= 0;
                            em[d] <= 0; en[d] <= 0; ek[d] <= 0;
                        end
                        1: if (ld[d]) ph[d] <= 2;
                        2: if (tr[d]) begin
                            if (idx[d] == n_tiles(d) - 1) begin
                                ph[d] <= 3; row[d] <= 0;
                            end else begin
                                idx[d] <= idx[d] + 1;
                                em[d] <= t_m(d, idx[d] + 1, mo[d]);
                                ek[d] <= t_k(d, idx[d] + 1, mo[d]);
                                en[d] <= t_n(d, idx[d] + 1);
                            end
                        end
                        default: if (orr[d]) begin
                            if (row[d] == dim_m(d) - 1) begin
                                ph[d] <= 0; row[d] <= 0; edn[d] <= 1'b1;
                            end else begin
                                row[d] <= row[d] + 1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;
    int nwd[2], naf[2], nal[2], ndn[2];
    logic [23:0] tq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_tile_valid", d), 32'(tv[d]), 32'(ph[d] == 2));
                chk($sformatf("d%0d_write_d", d),    32'(wd[d]), 32'(ph[d] == 2 && tr[d]));
                chk($sformatf("d%0d_acc_first", d),  32'(af[d]), 32'(ph[d] == 2 && ek[d] == 0));
                chk($sformatf("d%0d_acc_last", d),   32'(al[d]), 32'(ph[d] == 2 && ek[d] == dim_k(d) - 4));
                chk($sformatf("d%0d_ptr_m", d),      32'(pm[d]), 32'(em[d]));
                chk($sformatf("d%0d_ptr_n", d),      32'(pn[d]), 32'(en[d]));
                chk($sformatf("d%0d_ptr_k", d),      32'(pk[d]), 32'(ek[d]));
                chk($sformatf("d%0d_out_valid", d),  32'(ov[d]), 32'(ph[d] == 3));
                chk($sformatf("d%0d_row_out", d),    32'(ro[d]), 32'(row[d]));
                chk($sformatf("d%0d_busy", d),       32'(bz[d]), 32'(ph[d] != 0));
                chk($sformatf("d%0d_done", d),       32'(dn[d]), 32'(edn[d]));
                if (wd[d] === 1'b1) begin
                    nwd[d]++;
                    if (d == 0) tq.push_back({pm[0], pk[0], pn[0]});
                end
                if (af[d] === 1'b1) naf[d]++;
                if (al[d] === 1'b1) nal[d]++;
                if (dn[d] === 1'b1) ndn[d]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int d, input bit o);
        st[d] = 1'b1; lo[d] = o;
        tick();
        st[d] = 1'b0; ld[d] = 1'b1;
        tick();
        ld[d] = 1'b0;
    endtask

    task automatic compute(input int d, input int trm);
        int c = 0;
        while (tv[d] === 1'b1 && c < 5000) begin
            tr[d] = (trm == 0) ? 1'b1 : ((c % 3) == 0);
            tick();
            c++;
        end
        tr[d] = 1'b0;
        if (c >= 5000) chk("compute_timeout", 1, 0);
    endtask

    task automatic output_rows(input int d, output int rows);
        int c = 0;
        while (ov[d] === 1'b1 && c < 1000) begin
            chk("row_sequence", 32'(ro[d]), 32'(c));
            orr[d] = 1'b1;
            tick();
            c++;
        end
        orr[d] = 1'b0;
        rows = c;
        tick();
    endtask

    int b_q, b_wd, b_af, b_al, b_dn, rows;

    task automatic snap(input int d);
        b_q = tq.size(); b_wd = nwd[d]; b_af = naf[d]; b_al = nal[d]; b_dn = ndn[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; st = '0; lo = '0; ld = '0; ab = '0; tr = '0; orr = '0;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        chk("reset_busy",  32'(bz[0]), 0);
        chk("reset_ptr_m", 32'(pm[0]), 0);
        chk("reset_done",  32'(dn[0]), 0);
        reset = 1'b1;
        tick();

        // Order 0, full throughput.
        snap(0);
        start_load(0, 1'b0);
        compute(0, 0);
        output_rows(0, rows);
        chk("o0_tile_count", 32'(tq.size() - b_q), 64);
        chk("o0_tile_first", 32'(tq[b_q]),      32'({8'd0, 8'd0, 8'd0}));
        chk("o0_tile_5th",   32'(tq[b_q + 4]),  32'({8'd0, 8'd4, 8'd0}));
        chk("o0_tile_last",  32'(tq[b_q + 63]), 32'({8'd12, 8'd12, 8'd12}));
        chk("o0_rows",       32'(rows), 16);
        chk("o0_done_count", 32'(ndn[0] - b_dn), 1);

        // Order 1, k fastest.
        snap(0);
        start_load(0, 1'b1);
        compute(0, 0);
        output_rows(0, rows);
        chk("o1_tile_2nd",   32'(tq[b_q + 1]), 32'({8'd0, 8'd4, 8'd0}));
        chk("o1_tile_5th",   32'(tq[b_q + 4]), 32'({8'd4, 8'd0, 8'd0}));
        chk("o1_acc_first",  32'(naf[0] - b_af), 16);
        chk("o1_acc_last",   32'(nal[0] - b_al), 16);

        // Stalled handshake.
        snap(0);
        start_load(0, 1'b0);
        compute(0, 1);
        output_rows(0, rows);
        chk("stall_write_d_count", 32'(nwd[0] - b_wd), 64);
        chk("stall_done_count",    32'(ndn[0] - b_dn), 1);

        // Abort at tile 20, then restart.
        snap(0);
        start_load(0, 1'b0);
        tr[0] = 1'b1;
        repeat (20) tick();
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0; tr[0] = 1'b0;
        chk("abort_busy",       32'(bz[0]), 0);
        chk("abort_tile_valid", 32'(tv[0]), 0);
        tick();
        chk("abort_done_count", 32'(ndn[0] - b_dn), 0);
        snap(0);
        start_load(0, 1'b0);
        compute(0, 0);
        output_rows(0, rows);
        chk("restart_first_tile", 32'(tq[b_q]), 32'({8'd0, 8'd0, 8'd0}));
        chk("restart_tiles",      32'(tq.size() - b_q), 64);

        // Output backpressure, then reset at row 7.
        start_load(0, 1'b0);
        compute(0, 0);
        repeat (3) tick();
        chk("bp_row_hold",  32'(ro[0]), 0);
        chk("bp_out_valid", 32'(ov[0]), 1);
        orr[0] = 1'b1;
        repeat (7) tick();
        orr[0] = 1'b0;
        chk("bp_row_7", 32'(ro[0]), 7);
        reset = 1'b0;
        tick();
        chk("rst_busy",      32'(bz[0]), 0);
        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_row_out",   32'(ro[0]), 0);
        chk("rst_ptrs",      32'({pm[0], pn[0], pk[0]}), 0);
        chk("rst_done",      32'(dn[0]), 0);
        reset = 1'b1;
        tick();

        // 8x12x4 unit: K is a single tile.
        snap(1);
        start_load(1, 1'b0);
        compute(1, 0);
        output_rows(1, rows);
        chk("small_tiles",     32'(nwd[1] - b_wd), 6);
        chk("small_acc_first", 32'(naf[1] - b_af), 6);
        chk("small_acc_last",  32'(nal[1] - b_al), 6);
        chk("small_rows",      32'(rows), 8);
        chk("small_done",      32'(ndn[1] - b_dn), 1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
